// File: rtl/matmul_pkg.sv
// Shared types and constants for the tile-scheduled matrix multiplier.
package matmul_pkg;

    localparam int W    = 32;
    localparam int TILE = 2;

    typedef logic [W-1:0]            elem_t;
    typedef logic [1:0][1:0][W-1:0]  tile_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/matmul_tile_idx_ctr.sv
// Nested tile index counter: k is the innermost index, then j, then i.
module matmul_tile_idx_ctr #(
    parameter int NB = 2,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          step_i,
    output logic [IW-1:0] i_o,
    output logic [IW-1:0] j_o,
    output logic [IW-1:0] k_o,
    output logic          last_o,
    output logic          k_first_o
);

    localparam logic [IW-1:0] MAX = IW'(NB - 1);

    logic [IW-1:0] i_q, j_q, k_q;
    logic [IW-1:0] i_d, j_d, k_d;

    // Next index: clear on a new job, otherwise ripple k -> j -> i on each step.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (step_i) begin
            if (k_q != MAX) begin
                k_d = k_q + IW'(1);
            end else begin
                k_d = '0;
                if (j_q != MAX) begin
                    j_d = j_q + IW'(1);
                end else begin
                    j_d = '0;
                    i_d = (i_q != MAX) ? i_q + IW'(1) : '0;
                end
            end
        end
    end

    // Index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o       = i_q;
    assign j_o       = j_q;
    assign k_o       = k_q;
    assign last_o    = (i_q == MAX) && (j_q == MAX) && (k_q == MAX);
    assign k_first_o = (k_q == '0);

endmodule

// File: rtl/matmul_tile_sched.sv
// Drives a DIMxDIM product C = A*B through an external 2x2 tile engine,
// accumulating partial tile products into C, with a stall watchdog.
module matmul_tile_sched #(
    parameter int W       = matmul_pkg::W,
    parameter int DIM     = 4,
    parameter int TILE    = matmul_pkg::TILE,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DIM-1:0][DIM-1:0][W-1:0] a_in,
    input  logic [DIM-1:0][DIM-1:0][W-1:0] b_in,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [DIM-1:0][DIM-1:0][W-1:0] c_out,
    output logic                           tile_start,
    output logic [1:0][1:0][W-1:0]         tile_x,
    output logic [1:0][1:0][W-1:0]         tile_y,
    input  logic                           tile_done,
    input  logic [1:0][1:0][W-1:0]         tile_p
);

    import matmul_pkg::*;

    localparam int NB  = DIM / TILE;
    localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LIM = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    if ((TILE != 2) || (DIM % TILE != 0)) begin : g_param_check
        $error("matmul_tile_sched: TILE must be 2 and DIM a multiple of TILE");
    end

    sched_state_e state_q, state_d;
    logic         err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [DIM-1:0][DIM-1:0][W-1:0] a_q, b_q, c_q, c_d;

    logic          ld_ops, ctr_clr, ctr_step, acc_en;
    logic [IW-1:0] tile_i, tile_j, tile_k;
    logic          idx_last, k_first;

    matmul_tile_idx_ctr #(
        .NB (NB),
        .IW (IW)
    ) u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (ctr_clr),
        .step_i    (ctr_step),
        .i_o       (tile_i),
        .j_o       (tile_j),
        .k_o       (tile_k),
        .last_o    (idx_last),
        .k_first_o (k_first)
    );

    // Sequencer: next state, strobes and watchdog count.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        wd_d       = wd_q;
        ld_ops     = 1'b0;
        ctr_clr    = 1'b0;
        ctr_step   = 1'b0;
        acc_en     = 1'b0;
        busy       = (state_q != IDLE);
        done       = 1'b0;
        tile_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ld_ops  = 1'b1;
                    ctr_clr = 1'b1;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tile_start = 1'b1;
                wd_d       = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (tile_done) begin
                    acc_en   = 1'b1;
                    ctr_step = 1'b1;
                    state_d  = idx_last ? DONE : ISSUE;
                end else if (TIMEOUT > 0) begin
                    // Abort on the TIMEOUT-th consecutive WAIT cycle without a result.
                    if (wd_q == WD_LIM) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Sticky error flag and watchdog counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            wd_q  <= '0;
        end else begin
            err_q <= err_d;
            wd_q  <= wd_d;
        end
    end

    // Operand capture on the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (ld_ops) begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    // Operand tile mux: X = A tile (i,k), Y = B tile (k,j).
    for (genvar r = 0; r < 2; r++) begin : g_tr
        for (genvar c = 0; c < 2; c++) begin : g_tc
            assign tile_x[r][c] = a_q[{tile_i, 1'(r)}][{tile_k, 1'(c)}];
            assign tile_y[r][c] = b_q[{tile_k, 1'(r)}][{tile_j, 1'(c)}];
        end
    end

    // Accumulator next value: k==0 overwrites, later k add (mod 2^W).
    for (genvar rr = 0; rr < DIM; rr++) begin : g_row
        for (genvar cc = 0; cc < DIM; cc++) begin : g_col
            localparam int TR = rr % 2;
            localparam int TC = cc % 2;
            logic hit;
            assign hit = acc_en && (tile_i == IW'(rr / 2)) && (tile_j == IW'(cc / 2));
            assign c_d[rr][cc] = !hit    ? c_q[rr][cc] :
                                 k_first ? tile_p[TR][TC] :
                                           c_q[rr][cc] + tile_p[TR][TC];
        end
    end

    // Result matrix register.
    always_ff @(posedge clk) begin
        if (!rst_n) c_q <= '0;
        else        c_q <= c_d;
    end

    assign err   = err_q;
    assign c_out = c_q;

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Testbench for matmul_tile_sched with a latency-programmable 2x2 engine model.
module tb_matmul_tile_sched;

    typedef logic [3:0][3:0][31:0] mat_t;
    typedef logic [1:0][1:0][31:0] tl_t;

    localparam int DIM = 4;
    localparam int NT  = (DIM / 2) * (DIM / 2) * (DIM / 2);
    localparam int TO  = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    mat_t a_in, b_in, c_out;
    logic busy, done, err;
    logic tile_start, tile_done;
    tl_t  tile_x, tile_y, tile_p;

    int checks = 0;
    int passes = 0;

    // Engine model controls
    int   bfm_lat  = 1;
    int   bfm_drop = 0;
    bit   bfm_junk = 1'b0;
    int   bfm_seq  = 0;
    int   bfm_cnt  = 0;
    tl_t  bfm_prod;

    always #5 clk = ~clk;

    matmul_tile_sched #(
        .W(32), .DIM(DIM), .TILE(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .err(err), .c_out(c_out),
        .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y),
        .tile_done(tile_done), .tile_p(tile_p)
    );

    // 2x2 engine: result L cycles after tile_start; optional drop and junk pulses.
    always @(negedge clk) begin
        tile_done = 1'b0;
        if (!rst_n) begin
            bfm_cnt = 0;
        end else begin
            if (bfm_cnt > 0) begin
                bfm_cnt = bfm_cnt - 1;
                if (bfm_cnt == 0 && bfm_seq != bfm_drop) begin
                    tile_done = 1'b1;
                    tile_p    = bfm_prod;
                end
            end
            if (tile_start) begin
                bfm_seq = bfm_seq + 1;
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        bfm_prod[r][c] = tile_x[r][0] * tile_y[0][c] + tile_x[r][1] * tile_y[1][c];
                bfm_cnt = bfm_lat;
            end
            if (bfm_junk && !tile_done && (tile_start || !busy)) begin
                tile_done = 1'b1;
                tile_p    = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    function automatic mat_t ref_mul(input mat_t a, input mat_t b);
        mat_t        c;
        logic [31:0] s;
        c = '0;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                s = '0;
                for (int k = 0; k < 4; k++) s = s + a[r][k] * b[k][q];
                c[r][q] = s;
            end
        return c;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) m[r][q] = $urandom;
        return m;
    endfunction

    function automatic mat_t fill_mat(input logic [31:0] v);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) m[r][q] = v;
        return m;
    endfunction

    // Accept one job and count cycles (accept cycle = 0) until done or err.
    task automatic run_op(input mat_t a, input mat_t b, input bit pester,
                          output int lat, output bit got_err);
        lat     = -1;
        got_err = 1'b0;
        bfm_seq = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = 1'b0;
            a_in  = rand_mat();
            b_in  = rand_mat();
            if (pester && (n == 3 || n == 9 || n == 16)) start = 1'b1;
            if (done) begin lat = n; break; end
            if (err)  begin lat = n; got_err = 1'b1; break; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = rand_mat();
        b_in  = rand_mat();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
        checks++; if (tile_start !== 1'b0) $display("FAIL reset_tile_start: got %b want 0", tile_start); else passes++;
        checks++; if (c_out !== '0) $display("FAIL reset_c_out: got %h want 0", c_out); else passes++;
        checks++; if (tile_x !== '0 || tile_y !== '0) $display("FAIL reset_tiles: got %h/%h want 0", tile_x, tile_y); else passes++;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL start_in_reset_ignored: busy %b want 0", busy); else passes++;
    endtask

    task automatic test_identity();
        mat_t a, b;
        int   lat;
        bit   e;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                a[r][q] = (r == q) ? 32'd1 : 32'd0;
                b[r][q] = 32'(4 * r + q + 1);
            end
        bfm_lat = 1;
        run_op(a, b, 1'b0, lat, e);
        checks++; if (lat !== 1 + NT * 2) $display("FAIL identity_latency: got %0d want %0d", lat, 1 + NT * 2); else passes++;
        checks++; if (c_out !== b) $display("FAIL identity_result: got %h want %h", c_out, b); else passes++;
        checks++; if (err !== 1'b0) $display("FAIL identity_err: got %b want 0", err); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL identity_after_done: busy %b done %b want 0 0", busy, done); else passes++;
    endtask

    task automatic test_ones_l3();
        int lat;
        bit e;
        bfm_lat = 3;
        run_op(fill_mat(32'd1), fill_mat(32'd1), 1'b0, lat, e);
        checks++; if (lat !== 1 + NT * 4) $display("FAIL ones_latency: got %0d want %0d", lat, 1 + NT * 4); else passes++;
        checks++; if (c_out !== fill_mat(32'd4)) $display("FAIL ones_result: got %h want all 4", c_out); else passes++;
        bfm_lat = 1;
    endtask

    task automatic test_wrap();
        int lat;
        bit e;
        bfm_lat = 2;
        run_op(fill_mat(32'hFFFF_FFFF), fill_mat(32'hFFFF_FFFF), 1'b0, lat, e);
        checks++; if (lat !== 1 + NT * 3) $display("FAIL wrap_latency: got %0d want %0d", lat, 1 + NT * 3); else passes++;
        checks++; if (c_out !== fill_mat(32'h0000_0004)) $display("FAIL wrap_result: got %h want all 4", c_out); else passes++;
        bfm_lat = 1;
    endtask

    task automatic test_random();
        mat_t a, b, exp_c;
        int   lat, l;
        bit   e;
        for (int it = 0; it < 3; it++) begin
            a       = rand_mat();
            b       = rand_mat();
            exp_c   = ref_mul(a, b);
            l       = $urandom_range(1, 4);
            bfm_lat = l;
            run_op(a, b, 1'b0, lat, e);
            checks++; if (lat !== 1 + NT * (l + 1)) $display("FAIL random_latency[%0d]: got %0d want %0d", it, lat, 1 + NT * (l + 1)); else passes++;
            checks++; if (c_out !== exp_c) $display("FAIL random_result[%0d]: got %h want %h", it, c_out, exp_c); else passes++;
        end
        bfm_lat = 1;
    endtask

    task automatic test_ignored_inputs();
        mat_t a, b;
        int   lat;
        bit   e;
        for (int r = 0; r < 4; r++)
            for (int q = 0; q < 4; q++) begin
                a[r][q] = (r == q) ? 32'd1 : 32'd0;
                b[r][q] = 32'(4 * r + q + 1);
            end
        bfm_lat  = 1;
        bfm_junk = 1'b1;
        repeat (3) @(negedge clk);
        run_op(a, b, 1'b1, lat, e);
        checks++; if (lat !== 1 + NT * 2) $display("FAIL ignored_latency: got %0d want %0d", lat, 1 + NT * 2); else passes++;
        checks++; if (c_out !== b) $display("FAIL ignored_result: got %h want %h", c_out, b); else passes++;
        repeat (4) @(negedge clk);
        checks++; if (c_out !== b || busy !== 1'b0) $display("FAIL ignored_idle_hold: c %h busy %b want %h 0", c_out, busy, b); else passes++;
        bfm_junk = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        mat_t a, b, exp_c;
        int   lat;
        bit   e, blk_ok;
        a        = rand_mat();
        b        = rand_mat();
        exp_c    = ref_mul(a, b);
        bfm_lat  = 1;
        bfm_drop = 3;
        run_op(a, b, 1'b0, lat, e);
        // Third tile issued in cycle 5, TIMEOUT silent WAIT cycles follow, err seen next.
        checks++; if (e !== 1'b1) $display("FAIL timeout_err_seen: got %b want 1", e); else passes++;
        checks++; if (lat !== 1 + 2 * 2 + TO + 1) $display("FAIL timeout_cycle: got %0d want %0d", lat, 1 + 2 * 2 + TO + 1); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL timeout_idle: busy %b want 0", busy); else passes++;
        blk_ok = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++)
                if (c_out[r][q] !== exp_c[r][q]) blk_ok = 1'b0;
        checks++; if (blk_ok !== 1'b1) $display("FAIL timeout_partial_c: got %h want block00 of %h", c_out, exp_c); else passes++;
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1 || done !== 1'b0) $display("FAIL timeout_sticky: err %b done %b want 1 0", err, done); else passes++;
        bfm_drop = 0;
        a        = rand_mat();
        b        = rand_mat();
        exp_c    = ref_mul(a, b);
        run_op(a, b, 1'b0, lat, e);
        checks++; if (e !== 1'b0 || err !== 1'b0) $display("FAIL timeout_recover_err: saw %b err %b want 0 0", e, err); else passes++;
        checks++; if (lat !== 1 + NT * 2) $display("FAIL timeout_recover_latency: got %0d want %0d", lat, 1 + NT * 2); else passes++;
        checks++; if (c_out !== exp_c) $display("FAIL timeout_recover_result: got %h want %h", c_out, exp_c); else passes++;
    endtask

    task automatic test_reset_mid();
        mat_t a, b, exp_c;
        int   lat;
        bit   e;
        bfm_lat = 8;
        bfm_seq = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = rand_mat();
        b_in  = rand_mat();
        @(negedge clk);
        start = 1'b0;
        checks++; if (tile_start !== 1'b1) $display("FAIL midrst_issue: tile_start %b want 1", tile_start); else passes++;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tile_start !== 1'b0)
            $display("FAIL midrst_ctrl: busy %b done %b err %b ts %b want 0", busy, done, err, tile_start); else passes++;
        checks++; if (c_out !== '0) $display("FAIL midrst_c_out: got %h want 0", c_out); else passes++;
        checks++; if (tile_x !== '0 || tile_y !== '0) $display("FAIL midrst_tiles: got %h/%h want 0", tile_x, tile_y); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL midrst_stays_idle: busy %b want 0", busy); else passes++;
        bfm_lat = 1;
        a       = rand_mat();
        b       = rand_mat();
        exp_c   = ref_mul(a, b);
        run_op(a, b, 1'b0, lat, e);
        checks++; if (lat !== 1 + NT * 2) $display("FAIL midrst_rerun_latency: got %0d want %0d", lat, 1 + NT * 2); else passes++;
        checks++; if (c_out !== exp_c) $display("FAIL midrst_rerun_result: got %h want %h", c_out, exp_c); else passes++;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        tile_p = '0;
        test_reset();
        test_identity();
        test_ones_l3();
        test_wrap();
        test_random();
        test_ignored_inputs();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
